// File: rtl/life_gen_scheduler.sv
// life_gen_scheduler: frame-locked scheduler for a double-buffered Game of Life update engine.
// Launches clear/compute generations and swaps display/compute banks only on vsync edges.
module life_gen_scheduler #(
    parameter int unsigned VSPP  = 0,
    parameter int unsigned SPD_W = 8,
    parameter int unsigned GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             run,
    input  logic             step,
    input  logic             clear_req,
    input  logic [SPD_W-1:0] speed,
    output logic             eng_start,
    output logic             eng_clear,
    input  logic             eng_done,
    output logic             display_bank,
    output logic             compute_bank,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count,
    output logic             frame_overrun
);
    typedef enum logic [1:0] {IDLE, START, COMPUTE, SWAP_WAIT} state_t;

    state_t           state_q, state_d;
    logic             vs_q, vs_act, frame_tick;
    logic             step_pend_q, step_pend_d, clr_pend_q, clr_pend_d;
    logic             eng_clear_q, eng_clear_d, bank_q, bank_d, overrun_q, overrun_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [SPD_W-1:0] fcnt_q, fcnt_d, fcnt_inc, spd_eff;
    logic             run_due, swap;

    assign vs_act     = (VSPP != 0) ? vsync : ~vsync;
    assign frame_tick = vs_act & ~vs_q;
    assign fcnt_inc   = fcnt_q + SPD_W'(1);
    assign spd_eff    = (speed == '0) ? SPD_W'(1) : speed;

    always_comb begin
        state_d     = state_q;
        step_pend_d = step_pend_q | step;
        clr_pend_d  = clr_pend_q | clear_req;
        eng_clear_d = eng_clear_q;
        overrun_d   = overrun_q;
        fcnt_d      = fcnt_q;
        run_due     = 1'b0;
        swap        = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick && run) begin
                    run_due = fcnt_inc >= spd_eff;
                    fcnt_d  = run_due ? '0 : fcnt_inc;
                end
                // A request arriving in the launch cycle is a fresh request, so it re-latches
                if (clr_pend_q) begin
                    state_d     = START;
                    eng_clear_d = 1'b1;
                    clr_pend_d  = clear_req;
                    overrun_d   = 1'b0;
                    fcnt_d      = '0;
                end else if (step_pend_q) begin
                    state_d     = START;
                    eng_clear_d = 1'b0;
                    step_pend_d = step;
                end else if (run_due) begin
                    state_d     = START;
                    eng_clear_d = 1'b0;
                end
            end
            START: state_d = COMPUTE;
            COMPUTE: begin
                if (eng_done) begin
                    swap    = frame_tick;
                    state_d = frame_tick ? IDLE : SWAP_WAIT;
                end else if (frame_tick) begin
                    overrun_d = 1'b1;
                end
            end
            SWAP_WAIT: begin
                swap    = frame_tick;
                state_d = frame_tick ? IDLE : SWAP_WAIT;
            end
            default: state_d = IDLE;
        endcase
        bank_d = swap ? ~bank_q : bank_q;
        gen_d  = !swap ? gen_q : (eng_clear_q ? '0 : gen_q + GEN_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vs_q        <= 1'b0;
            step_pend_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            eng_clear_q <= 1'b0;
            bank_q      <= 1'b0;
            overrun_q   <= 1'b0;
            gen_q       <= '0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            vs_q        <= vs_act;
            step_pend_q <= step_pend_d;
            clr_pend_q  <= clr_pend_d;
            eng_clear_q <= eng_clear_d;
            bank_q      <= bank_d;
            overrun_q   <= overrun_d;
            gen_q       <= gen_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign eng_start     = (state_q == START);
    assign eng_clear     = eng_clear_q;
    assign busy          = (state_q != IDLE);
    assign display_bank  = bank_q;
    assign compute_bank  = ~bank_q;
    assign gen_count     = gen_q;
    assign frame_overrun = overrun_q;
endmodule

// File: tb/tb_life_gen_scheduler.sv
// tb_life_gen_scheduler: randomized scenario bench for life_gen_scheduler.
// Expectations come from frame/generation arithmetic, not from the scheduler's state machine.
module tb_life_gen_scheduler;
    localparam int SPD_W = 8;
    localparam int GEN_W = 16;
    localparam int P     = 16;

    logic             clk = 1'b0, rst_n = 1'b1, vsync = 1'b1, run = 1'b0, step = 1'b0, clear_req = 1'b0;
    logic [SPD_W-1:0] speed = 8'd1;
    logic             eng_start, eng_clear, display_bank, compute_bank, busy, frame_overrun, eng_done;
    logic [GEN_W-1:0] gen_count;
    logic             auto_done = 1'b0, man_done = 1'b0;
    int               eng_auto = 1, lat = 4, timer = 0;
    int               checks = 0, bad = 0;
    int               n_tick = 0, n_start = 0, n_offtick = 0;
    bit               clr_log[$];
    int               tick_log[$];
    int               gen_log[$];
    bit               mon_act, mon_tick, act_prev = 1'b0, prev_tick = 1'b0, bank_prev = 1'b0;

    assign eng_done = auto_done | man_done;

    life_gen_scheduler #(.VSPP(0), .SPD_W(SPD_W), .GEN_W(GEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .run(run), .step(step), .clear_req(clear_req),
        .speed(speed), .eng_start(eng_start), .eng_clear(eng_clear), .eng_done(eng_done),
        .display_bank(display_bank), .compute_bank(compute_bank), .busy(busy),
        .gen_count(gen_count), .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    // Engine stand-in: answers each eng_start with eng_done lat cycles later.
    always @(posedge clk) begin
        #1;
        auto_done = 1'b0;
        if (timer > 0) begin
            timer--;
            if (timer == 0) auto_done = 1'b1;
        end
        if (eng_start && eng_auto != 0) timer = lat;
        if (!rst_n) timer = 0;
    end

    always @(negedge clk) begin
        mon_act  = ~vsync;
        mon_tick = mon_act & ~act_prev;
        if (rst_n) begin
            if (mon_tick) n_tick++;
            if (eng_start) begin
                n_start++;
                clr_log.push_back(eng_clear);
                tick_log.push_back(n_tick);
            end
            if (display_bank != bank_prev) begin
                gen_log.push_back(int'(gen_count));
                if (!prev_tick) n_offtick++;
            end
        end
        prev_tick = mon_tick;
        bank_prev = display_bank;
        act_prev  = mon_act;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        n_tick = 0; n_start = 0; n_offtick = 0;
        clr_log.delete(); tick_log.delete(); gen_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vsync = 1'b1; run = 1'b0; step = 1'b0; clear_req = 1'b0;
        man_done = 1'b0; eng_auto = 1;
        cycles(3);
        rst_n = 1'b1;
        clr_mon();
    endtask

    task automatic pulse_step();
        step = 1'b1; cycles(1); step = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1; cycles(1); clear_req = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            vsync = 1'b0; cycles(1);
            vsync = 1'b1; cycles(P - 1);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (display_bank !== 1'b0) begin bad++; $display("FAIL reset_bank: got %b want 0", display_bank); end
        checks++; if (compute_bank !== 1'b1) begin bad++; $display("FAIL reset_cbank: got %b want 1", compute_bank); end
        checks++; if (eng_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", eng_start); end
        checks++; if (eng_clear !== 1'b0) begin bad++; $display("FAIL reset_clear: got %b want 0", eng_clear); end
        checks++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (gen_count !== '0) begin bad++; $display("FAIL reset_gen: got %0d want 0", gen_count); end
        checks++; if (frame_overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", frame_overrun); end
        do_reset();
    endtask

    task automatic test_run_speed();
        int s, se;
        for (int it = 0; it < 3; it++) begin
            s  = (it == 0) ? 3 : int'($urandom_range(0, 4));
            se = (s == 0) ? 1 : s;
            do_reset();
            lat = $urandom_range(2, 8); speed = SPD_W'(s); run = 1'b1;
            frames(3 * (se + 1));
            run = 1'b0; cycles(2);
            checks++; if (n_start !== 3) begin bad++; $display("FAIL run_starts s=%0d: got %0d want 3", s, n_start); end
            checks++; if (int'(gen_count) !== 3) begin bad++; $display("FAIL run_gen s=%0d: got %0d want 3", s, gen_count); end
            checks++; if (display_bank !== 1'b1) begin bad++; $display("FAIL run_bank s=%0d: got %b want 1", s, display_bank); end
            checks++; if (busy !== 1'b0 || frame_overrun !== 1'b0) begin bad++; $display("FAIL run_idle s=%0d: busy=%b ovr=%b want 0 0", s, busy, frame_overrun); end
            checks++; if (n_offtick !== 0) begin bad++; $display("FAIL run_offtick s=%0d: got %0d want 0", s, n_offtick); end
            for (int i = 0; i < tick_log.size(); i++) begin
                checks++;
                if (tick_log[i] % (se + 1) !== se || clr_log[i] !== 1'b0)
                    begin bad++; $display("FAIL run_launch s=%0d #%0d: tick=%0d clr=%b want tick%%%0d=%0d clr=0", s, i, tick_log[i], clr_log[i], se + 1, se); end
            end
            for (int i = 0; i < gen_log.size(); i++) begin
                checks++; if (gen_log[i] !== i + 1) begin bad++; $display("FAIL run_genseq s=%0d #%0d: got %0d want %0d", s, i, gen_log[i], i + 1); end
            end
        end
    endtask

    task automatic test_step();
        do_reset();
        speed = SPD_W'($urandom_range(0, 3)); lat = $urandom_range(2, 8);
        cycles($urandom_range(0, 5));
        pulse_step();
        frames(6);
        checks++; if (n_start !== 1) begin bad++; $display("FAIL step_starts: got %0d want 1", n_start); end
        checks++; if (clr_log.size() != 1 || clr_log[0] !== 1'b0) begin bad++; $display("FAIL step_clr: n=%0d want one with clr=0", clr_log.size()); end
        checks++; if (int'(gen_count) !== 1 || gen_log.size() != 1) begin bad++; $display("FAIL step_gen: got %0d swaps=%0d want 1 1", gen_count, gen_log.size()); end
        checks++; if (display_bank !== 1'b1 || compute_bank !== 1'b0) begin bad++; $display("FAIL step_bank: got %b/%b want 1/0", display_bank, compute_bank); end
        checks++; if (n_offtick !== 0) begin bad++; $display("FAIL step_offtick: got %0d want 0", n_offtick); end
    endtask

    task automatic test_clear_step();
        int g0;
        do_reset();
        lat = $urandom_range(2, 8);
        g0 = $urandom_range(1, 3);
        repeat (g0) begin pulse_step(); frames(2); end
        checks++; if (int'(gen_count) !== g0) begin bad++; $display("FAIL cs_pre_gen: got %0d want %0d", gen_count, g0); end
        clr_mon();
        clear_req = 1'b1; step = 1'b1; cycles(1); clear_req = 1'b0; step = 1'b0;
        frames(3);
        checks++; if (clr_log.size() != 2 || clr_log[0] !== 1'b1 || clr_log[1] !== 1'b0)
            begin bad++; $display("FAIL cs_order: n=%0d want launches clr=1 then clr=0", clr_log.size()); end
        checks++; if (gen_log.size() != 2 || gen_log[0] !== 0 || gen_log[1] !== 1)
            begin bad++; $display("FAIL cs_genseq: n=%0d want swaps loading 0 then 1", gen_log.size()); end
        checks++; if (int'(gen_count) !== 1) begin bad++; $display("FAIL cs_gen: got %0d want 1", gen_count); end
        checks++; if (int'(display_bank) !== g0 % 2) begin bad++; $display("FAIL cs_bank: got %b want %0d", display_bank, g0 % 2); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        lat = $urandom_range(3, 10);
        pulse_step(); cycles(2);
        checks++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
        step = 1'b1; cycles(1);
        step = 1'b0; clear_req = 1'b1; cycles(1);
        step = 1'b1; cycles(1);
        step = 1'b0; clear_req = 1'b0;
        cycles(12);
        frames(6);
        checks++; if (n_start !== 3) begin bad++; $display("FAIL b2b_starts: got %0d want 3", n_start); end
        checks++; if (clr_log.size() != 3 || clr_log[0] !== 1'b0 || clr_log[1] !== 1'b1 || clr_log[2] !== 1'b0)
            begin bad++; $display("FAIL b2b_order: n=%0d want clr 0,1,0", clr_log.size()); end
        checks++; if (gen_log.size() != 3 || gen_log[0] !== 1 || gen_log[1] !== 0 || gen_log[2] !== 1)
            begin bad++; $display("FAIL b2b_genseq: n=%0d want gens 1,0,1", gen_log.size()); end
        checks++; if (display_bank !== 1'b1 || busy !== 1'b0 || frame_overrun !== 1'b0)
            begin bad++; $display("FAIL b2b_end: bank=%b busy=%b ovr=%b want 1 0 0", display_bank, busy, frame_overrun); end
    endtask

    task automatic test_overrun();
        int k;
        k = $urandom_range(0, 3);
        do_reset();
        eng_auto = 0;
        pulse_step(); cycles(4);
        frames(k);
        checks++; if (busy !== 1'b1 || frame_overrun !== (k > 0))
            begin bad++; $display("FAIL ovr_set k=%0d: busy=%b ovr=%b want 1 %0d", k, busy, frame_overrun, k > 0); end
        man_done = 1'b1; cycles(1); man_done = 1'b0;
        frames(1);
        checks++; if (int'(gen_count) !== 1 || busy !== 1'b0 || frame_overrun !== (k > 0))
            begin bad++; $display("FAIL ovr_swap k=%0d: gen=%0d busy=%b ovr=%b want 1 0 %0d", k, gen_count, busy, frame_overrun, k > 0); end
        eng_auto = 1; lat = $urandom_range(2, 8);
        pulse_step(); frames(2);
        checks++; if (int'(gen_count) !== 2 || frame_overrun !== (k > 0))
            begin bad++; $display("FAIL ovr_sticky k=%0d: gen=%0d ovr=%b want 2 %0d", k, gen_count, frame_overrun, k > 0); end
        clr_mon();
        pulse_clear(); cycles(3);
        checks++; if (frame_overrun !== 1'b0 || n_start !== 1 || eng_clear !== 1'b1)
            begin bad++; $display("FAIL ovr_clear: ovr=%b starts=%0d clr=%b want 0 1 1", frame_overrun, n_start, eng_clear); end
        frames(2);
        checks++; if (gen_count !== '0 || display_bank !== 1'b1)
            begin bad++; $display("FAIL ovr_cleargen: gen=%0d bank=%b want 0 1", gen_count, display_bank); end
    endtask

    task automatic test_coincident();
        do_reset();
        eng_auto = 0;
        pulse_step(); cycles($urandom_range(3, 8));
        checks++; if (busy !== 1'b1 || display_bank !== 1'b0) begin bad++; $display("FAIL coin_pre: busy=%b bank=%b want 1 0", busy, display_bank); end
        vsync = 1'b0; man_done = 1'b1; cycles(1);
        vsync = 1'b1; man_done = 1'b0;
        checks++; if (display_bank !== 1'b1 || compute_bank !== 1'b0) begin bad++; $display("FAIL coin_bank: got %b/%b want 1/0", display_bank, compute_bank); end
        checks++; if (busy !== 1'b0) begin bad++; $display("FAIL coin_busy: got %b want 0", busy); end
        checks++; if (int'(gen_count) !== 1 || frame_overrun !== 1'b0) begin bad++; $display("FAIL coin_gen: gen=%0d ovr=%b want 1 0", gen_count, frame_overrun); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = $urandom_range(2, 8);
        pulse_step(); frames(2);
        eng_auto = 0;
        pulse_step(); cycles(4);
        checks++; if (busy !== 1'b1 || display_bank !== 1'b1) begin bad++; $display("FAIL rm_pre: busy=%b bank=%b want 1 1", busy, display_bank); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (display_bank !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_async: bank=%b busy=%b want 0 0", display_bank, busy); end
        checks++; if (gen_count !== '0 || eng_start !== 1'b0) begin bad++; $display("FAIL rm_state: gen=%0d start=%b want 0 0", gen_count, eng_start); end
        cycles(2);
        rst_n = 1'b1;
        clr_mon();
        man_done = 1'b1; cycles(1); man_done = 1'b0;
        frames(2);
        checks++; if (n_start !== 0 || gen_log.size() != 0 || display_bank !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL rm_late_done: starts=%0d swaps=%0d bank=%b busy=%b want 0 0 0 0", n_start, gen_log.size(), display_bank, busy); end
        eng_auto = 1;
        pulse_step(); frames(2);
        checks++; if (n_start !== 1 || clr_log.size() != 1 || clr_log[0] !== 1'b0 || int'(gen_count) !== 1 || display_bank !== 1'b1)
            begin bad++; $display("FAIL rm_relaunch: starts=%0d gen=%0d bank=%b want 1 1 1", n_start, gen_count, display_bank); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run_speed();
        test_step();
        test_clear_step();
        test_back_to_back();
        test_overrun();
        test_coincident();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end
endmodule

// File: doc/life_gen_scheduler.md
LIFE_GEN_SCHEDULER -- requirements
Module: life_gen_scheduler

Interface
REQ-001 SHALL have parameter VSPP, default 0, meaning vsync pulse polarity (0 negative, 1 positive).
REQ-002 SHALL have parameter SPD_W, default 8, meaning width of speed field.
REQ-003 SHALL have parameter GEN_W, default 16, meaning width of generation counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port vsync  input  1  vsync from display timing generator, polarity per VSPP, synchronous to clk.
REQ-007 SHALL have port run  input  1  level; free-running evolution enabled.
REQ-008 SHALL have port step  input  1  one-cycle pulse; request exactly one generation.
REQ-009 SHALL have port clear_req  input  1  one-cycle pulse; request board clear.
REQ-010 SHALL have port speed  input  SPD_W  frames per generation; 0 treated as 1.
REQ-011 SHALL have port eng_start  output  1  one-cycle pulse starting update engine.
REQ-012 SHALL have port eng_clear  output  1  qualifies eng_start: 1 = write all-dead, 0 = compute next generation.
REQ-013 SHALL have port eng_done  input  1  one-cycle pulse; engine finished writing compute bank.
REQ-014 SHALL have port display_bank  output  1  bank read by display; compute_bank output is its inverse.
REQ-015 SHALL have ports busy (1), gen_count (GEN_W), frame_overrun (1) as outputs.

Function
REQ-016 SHALL generate frame_tick, internal, for one cycle when vsync goes from inactive to active level (registered previous-value compare).
REQ-017 SHALL implement states IDLE, START, COMPUTE, SWAP_WAIT; busy = 1 in every state except IDLE.
REQ-018 SHALL latch step and clear_req into pending flags in any state; a pending flag clears only when its request is launched.
REQ-019 IDLE: on frame_tick with run=1, SHALL increment frame_cnt; generation due when incremented value >= max(speed,1), which also resets frame_cnt to 0.
REQ-020 IDLE launch priority SHALL be clear pending > step pending > run-due; launch moves to START and records eng_clear.
REQ-021 START SHALL assert eng_start for exactly one cycle with stable eng_clear, then enter COMPUTE.
REQ-022 COMPUTE SHALL wait for eng_done; frame_tick seen in COMPUTE without eng_done SHALL set frame_overrun (sticky).
REQ-023 eng_done in COMPUTE SHALL enter SWAP_WAIT; if frame_tick occurs the same cycle, the swap SHALL happen that cycle and state returns to IDLE.
REQ-024 SWAP_WAIT SHALL on next frame_tick toggle display_bank and return to IDLE; swaps occur only on frame_tick cycles.
REQ-025 On swap, gen_count SHALL increment (wrapping at 2^GEN_W) for a compute launch and load 0 for a clear launch.
REQ-026 Launch of a clear SHALL also clear frame_overrun and frame_cnt.
REQ-027 frame_cnt SHALL NOT advance outside IDLE; run deasserted mid-generation SHALL NOT abort it.
REQ-028 eng_done outside COMPUTE SHALL be ignored.
REQ-029 step and clear_req arriving during a generation SHALL be served in IDLE after it completes; duplicate pulses while pending SHALL collapse to one.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, display_bank=0, eng_start=0, eng_clear=0, busy=0, gen_count=0, frame_overrun=0, frame_cnt=0, pending flags=0, vsync history=inactive.
REQ-031 Reset mid-COMPUTE SHALL abandon the generation with no swap; first launch after release obeys REQ-020.

Verification
REQ-032 speed=3, run=1, engine done 10 cycles after eng_start -> eng_start after every 3rd vsync edge, display_bank toggles on following edge, gen_count 1,2,3.
REQ-033 run=0, one step pulse -> one eng_start with eng_clear=0, one swap, gen_count=1; no further eng_start over 5 frames.
REQ-034 clear_req and step same cycle in IDLE -> first eng_start eng_clear=1, swap loads gen_count=0, then second eng_start eng_clear=0, gen_count=1.
REQ-035 eng_done withheld across two vsync edges -> frame_overrun=1 stays 1 until clear launch.
REQ-036 eng_done coincident with vsync edge -> display_bank toggles that cycle, busy=0 next cycle.
REQ-037 rst_n low during COMPUTE with display_bank=1 -> display_bank=0, busy=0 asynchronously; late eng_done ignored.
